// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sharing one spi_master between NUM_CLIENTS burst requesters.
// Optional build macro SPI_ARB_TIMEOUT_EN adds a WAIT watchdog and the timeout_err output.
module spi_master_arbiter #(
    parameter int NUM_CLIENTS    = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int LEN_WIDTH      = 4,
    parameter int CS_GAP         = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                              clk,
    input  logic                              arstn,
    input  logic [NUM_CLIENTS-1:0]            req,
    input  logic [NUM_CLIENTS*LEN_WIDTH-1:0]  req_len,
    input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] tx_data,
    output logic [NUM_CLIENTS-1:0]            tx_ack,
    output logic [DATA_WIDTH-1:0]             rx_data,
    output logic [NUM_CLIENTS-1:0]            rx_valid,
    output logic [NUM_CLIENTS-1:0]            grant,
    output logic [NUM_CLIENTS-1:0]            ss_n,
    output logic                              busy,
    output logic [DATA_WIDTH-1:0]             m_data_send,
    output logic                              m_spi_start,
    input  logic                              m_spi_done,
    input  logic [DATA_WIDTH-1:0]             m_data_recv
`ifdef SPI_ARB_TIMEOUT_EN
    ,
    output logic                              timeout_err
`endif
);

    localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLIENTS - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);
`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       cur_q, cur_d;
    logic [IDX_W-1:0]       last_q, last_d;
    logic [LEN_WIDTH-1:0]   remain_q, remain_d;
    logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
    logic [NUM_CLIENTS-1:0] grant_q, grant_d;
    logic [NUM_CLIENTS-1:0] ss_n_q, ss_n_d;
    logic                   busy_q, busy_d;
    logic [NUM_CLIENTS-1:0] tx_ack_q, tx_ack_d;
    logic [DATA_WIDTH-1:0]  rx_data_q, rx_data_d;
    logic [NUM_CLIENTS-1:0] rx_valid_q, rx_valid_d;
    logic [DATA_WIDTH-1:0]  m_data_send_q, m_data_send_d;
    logic                   m_spi_start_q, m_spi_start_d;
`ifdef SPI_ARB_TIMEOUT_EN
    logic [TMO_W-1:0]       tmo_cnt_q, tmo_cnt_d;
    logic                   timeout_err_q, timeout_err_d;
`endif

    logic [DATA_WIDTH-1:0]  tx_word  [NUM_CLIENTS];
    logic [LEN_WIDTH-1:0]   len_word [NUM_CLIENTS];

    always_comb begin
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            tx_word[i]  = tx_data[i*DATA_WIDTH +: DATA_WIDTH];
            len_word[i] = req_len[i*LEN_WIDTH +: LEN_WIDTH];
        end
    end

    function automatic logic [NUM_CLIENTS-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_CLIENTS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Scan starts one past the last completed owner, so a client that keeps
    // req high waits until every other pending client has had a turn.
    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] scan_idx;

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        scan_idx  = '0;
        for (int k = 1; k <= NUM_CLIENTS; k++) begin
            scan_idx = IDX_W'((int'(last_q) + k) % NUM_CLIENTS);
            if (!sel_found && req[scan_idx]) begin
                sel_found = 1'b1;
                sel_idx   = scan_idx;
            end
        end
    end

    logic issue;
    logic to_gap;

    always_comb begin
        state_d       = state_q;
        cur_d         = cur_q;
        last_d        = last_q;
        remain_d      = remain_q;
        gap_cnt_d     = gap_cnt_q;
        grant_d       = grant_q;
        ss_n_d        = ss_n_q;
        busy_d        = busy_q;
        rx_data_d     = rx_data_q;
        m_data_send_d = m_data_send_q;
        tx_ack_d      = '0;
        rx_valid_d    = '0;
        m_spi_start_d = 1'b0;
        issue         = 1'b0;
        to_gap        = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
        tmo_cnt_d     = tmo_cnt_q;
        timeout_err_d = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    cur_d    = sel_idx;
                    grant_d  = onehot(sel_idx);
                    ss_n_d   = ~onehot(sel_idx);
                    busy_d   = 1'b1;
                    remain_d = len_word[sel_idx];
                    issue    = 1'b1;
                end
            end
            START: begin
                state_d = WAIT;
`ifdef SPI_ARB_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end
            WAIT: begin
                if (m_spi_done) begin
                    rx_data_d  = m_data_recv;
                    rx_valid_d = onehot(cur_q);
                    if (remain_q == '0) begin
                        to_gap = 1'b1;
                    end else begin
                        remain_d = remain_q - LEN_WIDTH'(1);
                        issue    = 1'b1;
                    end
                end
`ifdef SPI_ARB_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    to_gap        = 1'b1;
                    timeout_err_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
`endif
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Word launch is shared by the first word of a grant and every follow-on word.
        if (issue) begin
            m_spi_start_d = 1'b1;
            m_data_send_d = tx_word[cur_d];
            tx_ack_d      = onehot(cur_d);
            state_d       = START;
        end

        if (to_gap) begin
            grant_d   = '0;
            ss_n_d    = '1;
            last_d    = cur_q;
            gap_cnt_d = '0;
            state_d   = GAP;
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q       <= IDLE;
            cur_q         <= '0;
            last_q        <= LAST_IDX;
            remain_q      <= '0;
            gap_cnt_q     <= '0;
            grant_q       <= '0;
            ss_n_q        <= '1;
            busy_q        <= 1'b0;
            tx_ack_q      <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= '0;
            m_data_send_q <= '0;
            m_spi_start_q <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
            tmo_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cur_q         <= cur_d;
            last_q        <= last_d;
            remain_q      <= remain_d;
            gap_cnt_q     <= gap_cnt_d;
            grant_q       <= grant_d;
            ss_n_q        <= ss_n_d;
            busy_q        <= busy_d;
            tx_ack_q      <= tx_ack_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            m_data_send_q <= m_data_send_d;
            m_spi_start_q <= m_spi_start_d;
`ifdef SPI_ARB_TIMEOUT_EN
            tmo_cnt_q     <= tmo_cnt_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    assign grant       = grant_q;
    assign ss_n        = ss_n_q;
    assign busy        = busy_q;
    assign tx_ack      = tx_ack_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign m_data_send = m_data_send_q;
    assign m_spi_start = m_spi_start_q;
`ifdef SPI_ARB_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`endif

endmodule
